irq_arbiter_12: RTL
===================

Name: irq_arbiter_12

Overview:
- Interrupt controller for the pipelined CPU. Collects 12 external or internal request lines, applies a software mask and fixed priority, and presents one request with its source ID to the CPU.
- Uses a Request/Ack/Done handshake with the exception logic in the EX/MEM stage.
- Tracks the in-service source so the CPU's ERET path can retire it.

Parameters:
- EDGE_MASK, 12'h000, per-source trigger select. Bit i = 1: source i is rising-edge triggered. Bit i = 0: source i is level triggered.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Irq_In  input  12  raw request lines. Bit 0 has the highest priority.
- Mask_In  input  12  new mask value. Bit = 1 masks the source.
- Mask_We  input  1  loads Mask_In into the mask register.
- Irq_Ack  input  1  CPU accepts the current request (pulse, only honoured in REQ).
- Irq_Done  input  1  CPU finished service (ERET pulse, only honoured in SERVICE).
- Irq_Req  output  1  registered request to the CPU.
- Irq_Id  output  4  registered ID of the requested source, range 0..11.
- Any_Pending  output  1  OR of (Pending & ~Mask). Combinational from registers only.
- Pending  output  12  pending register.
- In_Service  output  12  in-service register.
- Mask_Out  output  12  current mask register.

Behaviour:
- Reset values: Pending = 0, In_Service = 0, Mask = 12'hFFF (all masked), Irq_Req = 0, Irq_Id = 0, FSM = IDLE, edge-detect history = 0. Reset overrides every other input, including mid-REQ or mid-SERVICE.
- Edge source i: Pending[i] sets when Irq_In[i] = 1 and the previous sample = 0. It clears only on Ack of ID i. If a set and an Ack-clear of the same bit land in the same cycle, the set wins.
- Level source i: Pending[i] = the registered Irq_In[i] every cycle. Ack does not clear it.
- Mask_We updates Mask on the next edge. A new mask affects eligibility from the following cycle.
- Eligible = Pending & ~Mask. The winner is the lowest set index.
- FSM states:
  - IDLE: if any bit is eligible, latch the winner into Irq_Id, set Irq_Req = 1, go to REQ.
  - REQ: Irq_Req and Irq_Id are held stable until Irq_Ack, even if the source is later masked or deasserted. On Irq_Ack: Irq_Req = 0, In_Service[Irq_Id] = 1, clear Pending[Irq_Id] if it is an edge source, go to SERVICE.
  - SERVICE: on Irq_Done, clear In_Service[Irq_Id] and go to IDLE. Arbitration resumes on the next cycle, so there is at least one idle cycle between Done and the next Irq_Req.
- Latency: an Irq_In edge at rising edge k gives Pending at k+1, then Irq_Req high after edge k+1. That is 2 cycles.
- Protocol errors: Irq_Ack outside REQ and Irq_Done outside SERVICE are ignored.
- Irq_Ack and Irq_Done asserted together in REQ: only the Ack is taken.

Optional Feature:
- Macro: IRQ_NESTING_EN.
- When defined, in SERVICE the arbiter re-arbitrates. An eligible source with an index strictly lower than the lowest set In_Service bit raises Irq_Req again with its ID. Ack adds that bit to In_Service, which can hold multiple bits. Irq_Done clears the lowest set In_Service bit. The FSM returns to IDLE only when In_Service becomes 0.
- Nesting depth is bounded at 12. Irq_Id in SERVICE reports the most recent grant.
- When undefined, Irq_Req stays 0 throughout SERVICE and In_Service is one-hot or zero.

Test Plan:
- Reset, then Mask_We with Mask_In = 12'h000, then a rising edge on Irq_In[5] (EDGE_MASK = 12'h020) -> Irq_Req = 1 and Irq_Id = 5 two cycles later. Ack -> Pending[5] = 0, In_Service = 12'h020. Done -> In_Service = 0, state IDLE.
- Irq_In = 12'h900 level, Mask = 12'h800 -> Irq_Id = 8. Then Mask = 12'h100 after Done -> next request has Irq_Id = 11.
- Mask stays 12'hFFF with Irq_In = 12'hFFF -> Irq_Req stays 0, Pending = 12'hFFF, Any_Pending = 0.
- Ack in the same cycle as a new edge on the acked source -> Pending bit remains 1, and it re-requests after Done.
- Reset asserted during SERVICE with In_Service = 12'h004 -> next cycle all registers are at reset values and Irq_Req = 0.
- IRQ_NESTING_EN: in SERVICE for ID 6, raise source 2 -> Irq_Req = 1 with Irq_Id = 2. Ack -> In_Service = 12'h044. Done -> 12'h040. Done -> 0 and IDLE. Without the macro, Irq_Req stays 0 until the first Done.

Source files
------------

// File: rtl/irq_arbiter_12.sv
// 12-source interrupt arbiter: per-source edge/level capture, software mask, fixed priority
// (bit 0 highest) and a Req/Ack/Done handshake. Define IRQ_NESTING_EN for nested service.
module irq_arbiter_12 #(
    parameter logic [11:0] EDGE_MASK = 12'h000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [11:0] Irq_In,
    input  logic [11:0] Mask_In,
    input  logic        Mask_We,
    input  logic        Irq_Ack,
    input  logic        Irq_Done,
    output logic        Irq_Req,
    output logic [3:0]  Irq_Id,
    output logic        Any_Pending,
    output logic [11:0] Pending,
    output logic [11:0] In_Service,
    output logic [11:0] Mask_Out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [11:0] pending_reg, pending_next;
    logic [11:0] in_service_reg, in_service_next;
    logic [11:0] mask_reg;
    logic [11:0] irq_hist_reg;
    logic        irq_req_reg, irq_req_next;
    logic [3:0]  irq_id_reg, irq_id_next;

    logic [11:0] eligible;
    logic        any_elig;
    logic [3:0]  win_idx;
    logic [11:0] id_onehot;
    logic        ack_take;
    logic [11:0] pend_clr;

    assign eligible  = pending_reg & ~mask_reg;
    assign any_elig  = |eligible;
    assign id_onehot = 12'(1) << irq_id_reg;
    assign pend_clr  = ack_take ? (id_onehot & EDGE_MASK) : 12'h000;

    // A fresh edge beats a same-cycle Ack clear; level sources just track the input.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_pend
            assign pending_next[gi] = EDGE_MASK[gi]
                ? ((Irq_In[gi] & ~irq_hist_reg[gi]) | (pending_reg[gi] & ~pend_clr[gi]))
                : Irq_In[gi];
        end
    endgenerate

    // Scan downward so the lowest eligible index is the last one written.
    always_comb begin
        win_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (eligible[i]) win_idx = 4'(i);
        end
    end

`ifdef IRQ_NESTING_EN
    logic [11:0] ins_lsb;
    logic [11:0] ins_below;
    logic [11:0] ins_after_done;
    logic        nest_hit;
    logic        done_take;

    assign ins_lsb        = in_service_reg & (~in_service_reg + 12'd1);
    assign ins_below      = ins_lsb - 12'd1;
    assign ins_after_done = in_service_reg & ~ins_lsb;
    assign nest_hit       = |(eligible & ins_below);
    assign done_take      = Irq_Done && !(irq_req_reg && Irq_Ack);
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            pending_reg    <= 12'h000;
            in_service_reg <= 12'h000;
            mask_reg       <= 12'hFFF;
            irq_hist_reg   <= 12'h000;
            irq_req_reg    <= 1'b0;
            irq_id_reg     <= 4'd0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            irq_hist_reg   <= Irq_In;
            irq_req_reg    <= irq_req_next;
            irq_id_reg     <= irq_id_next;
            if (Mask_We) mask_reg <= Mask_In;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (any_elig) state_next = ST_REQ;
            ST_REQ:     if (Irq_Ack) state_next = ST_SERVICE;
            ST_SERVICE: begin
`ifdef IRQ_NESTING_EN
                // An outstanding nested request survives the stack emptying.
                if (done_take && ins_after_done == 12'h000)
                    state_next = irq_req_reg ? ST_REQ : ST_IDLE;
`else
                if (Irq_Done) state_next = ST_IDLE;
`endif
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_take        = 1'b0;
        irq_req_next    = irq_req_reg;
        irq_id_next     = irq_id_reg;
        in_service_next = in_service_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_elig) begin
                    irq_req_next = 1'b1;
                    irq_id_next  = win_idx;
                end
            end
            ST_REQ: begin
                if (Irq_Ack) begin
                    ack_take        = 1'b1;
                    irq_req_next    = 1'b0;
                    in_service_next = in_service_reg | id_onehot;
                end
            end
            ST_SERVICE: begin
`ifdef IRQ_NESTING_EN
                if (irq_req_reg && Irq_Ack) begin
                    ack_take        = 1'b1;
                    irq_req_next    = 1'b0;
                    in_service_next = in_service_reg | id_onehot;
                end else begin
                    if (Irq_Done) in_service_next = ins_after_done;
                    if (!irq_req_reg && !Irq_Done && nest_hit) begin
                        irq_req_next = 1'b1;
                        irq_id_next  = win_idx;
                    end
                end
`else
                if (Irq_Done) in_service_next = in_service_reg & ~id_onehot;
`endif
            end
            default: begin
                irq_req_next = 1'b0;
            end
        endcase
    end

    assign Irq_Req     = irq_req_reg;
    assign Irq_Id      = irq_id_reg;
    assign Any_Pending = |(pending_reg & ~mask_reg);
    assign Pending     = pending_reg;
    assign In_Service  = in_service_reg;
    assign Mask_Out    = mask_reg;

endmodule
